// File: rtl/mult_result_buffer_pipelined.sv
// ---------------------------------------------------------------------------
// mult_result_buffer_pipelined
//
// Accepts operand pairs over a valid/ready handshake. Each pair is multiplied
// in a PIPE_STAGES-deep pipeline, signed or unsigned. Products are stored in
// order in a DEPTH-entry two-port memory and then streamed out as one burst.
// A fill ends when the buffer is full or a flush is accepted. The block then
// drains the in-flight products before it offers the buffer for read-out.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   operandA     multiplicand            [A_WIDTH]
//   operandB     multiplier              [B_WIDTH]
//   EN_mult      operand valid, taken when EN_mult && RDY_mult
//   flush        end the current fill early (needs at least one operand)
//   EN_readMem   start a read burst, taken when EN_readMem && RDY_readMem
//   RDY_mult     ready for operands
//   RDY_readMem  buffer complete, a burst may start
//   memVal       burst read data         [A_WIDTH+B_WIDTH]
//   VALID_memVal memVal carries a stored product this cycle
//   fill_count   operands issued in the current fill, in-flight included
//
// memory_wrapper_2port
//   Port B writes. Port A reads with one cycle of latency. Both enables are
//   active-low. q keeps its value on cycles with no read.
// ---------------------------------------------------------------------------

module memory_wrapper_2port #(
    parameter int WIDTH    = 32,
    parameter int LOGDEPTH = 6
) (
    input  logic                clk,
    input  logic                cenA,
    input  logic [LOGDEPTH-1:0] aA,
    output logic [WIDTH-1:0]    q,
    input  logic                cenB,
    input  logic [LOGDEPTH-1:0] aB,
    input  logic [WIDTH-1:0]    d
);

    logic [WIDTH-1:0] mem [0:(1<<LOGDEPTH)-1];

    always_ff @(posedge clk) begin
        if (!cenB) mem[aB] <= d;
        if (!cenA) q <= mem[aA];
    end

endmodule

module mult_result_buffer_pipelined #(
    parameter int A_WIDTH     = 16,
    parameter int B_WIDTH     = 16,
    parameter int DEPTH       = 64,
    parameter int PIPE_STAGES = 2,
    parameter int SIGNED      = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [A_WIDTH-1:0]            operandA,
    input  logic [B_WIDTH-1:0]            operandB,
    input  logic                          EN_mult,
    input  logic                          flush,
    input  logic                          EN_readMem,
    output logic                          RDY_mult,
    output logic                          RDY_readMem,
    output logic [A_WIDTH+B_WIDTH-1:0]    memVal,
    output logic                          VALID_memVal,
    output logic [$clog2(DEPTH+1)-1:0]    fill_count
);

    localparam int P  = A_WIDTH + B_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {S_FILL, S_DRAIN, S_FULL, S_READ} state_t;

    // Both operands are extended to P bits. The multiply is then taken modulo
    // 2^P, which gives the exact full-precision product for signed and
    // unsigned operands alike.
    function automatic logic [P-1:0] mul_full(input logic [A_WIDTH-1:0] a,
                                              input logic [B_WIDTH-1:0] b);
        logic signed [P-1:0] ea;
        logic signed [P-1:0] eb;
        if (SIGNED != 0) begin
            ea = {{B_WIDTH{a[A_WIDTH-1]}}, a};
            eb = {{A_WIDTH{b[B_WIDTH-1]}}, b};
        end else begin
            ea = {{B_WIDTH{1'b0}}, a};
            eb = {{A_WIDTH{1'b0}}, b};
        end
        return ea * eb;
    endfunction

    state_t                 state, state_nxt;
    logic [CW-1:0]          rd_addr;
    logic                   fill_open;
    logic                   accept;
    logic                   flush_acc;
    logic                   last_slot;
    logic                   rd_active;
    logic                   rd_done;
    logic                   pipe_busy;

    logic [PIPE_STAGES-1:0] vld_p;
    logic [AW-1:0]          wa_p [PIPE_STAGES];
    logic [P-1:0]           wr_data;

    assign fill_open = (state == S_FILL) && (fill_count < DEPTH_C);
    assign accept    = EN_mult && fill_open;
    // A flush with nothing issued and nothing arriving is ignored.
    assign flush_acc = (state == S_FILL) && flush && ((fill_count != '0) || accept);
    assign last_slot = accept && (fill_count == DEPTH_C - CW'(1));
    assign rd_active = (state == S_READ) && (rd_addr != fill_count);
    assign rd_done   = (state == S_READ) && (rd_addr == fill_count);
    assign pipe_busy = |vld_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_FILL;
            fill_count   <= '0;
            rd_addr      <= '0;
            VALID_memVal <= 1'b0;
        end else begin
            state        <= state_nxt;
            VALID_memVal <= rd_active;
            if (accept)       fill_count <= fill_count + CW'(1);
            else if (rd_done) fill_count <= '0;
            if (rd_done)                rd_addr <= '0;
            else if (state == S_READ)   rd_addr <= rd_addr + CW'(1);
        end
    end

    always_comb begin
        state_nxt   = state;
        RDY_mult    = fill_open;
        RDY_readMem = (state == S_FULL);
        case (state)
            S_FILL:  if (last_slot || flush_acc) state_nxt = S_DRAIN;
            // The last write leaves the pipeline before read-out is offered.
            S_DRAIN: if (!pipe_busy)             state_nxt = S_FULL;
            S_FULL:  if (EN_readMem)             state_nxt = S_READ;
            S_READ:  if (rd_done)                state_nxt = S_FILL;
            default:                             state_nxt = S_FILL;
        endcase
    end

    // ---- stage p0 .. p(PIPE_STAGES-1): valid bits and write addresses ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= accept;
            for (int k = 1; k < PIPE_STAGES; k++) vld_p[k] <= vld_p[k-1];
        end
    end

    always_ff @(posedge clk) begin
        wa_p[0] <= fill_count[AW-1:0];
        for (int k = 1; k < PIPE_STAGES; k++) wa_p[k] <= wa_p[k-1];
    end

    // ---- data path: operands at p0, product from p1, delayed to the last stage ----
    if (PIPE_STAGES == 1) begin : g_one
        logic [P-1:0] prod_p0;
        always_ff @(posedge clk) prod_p0 <= mul_full(operandA, operandB);
        assign wr_data = prod_p0;
    end else begin : g_multi
        logic [A_WIDTH-1:0] a_p0;
        logic [B_WIDTH-1:0] b_p0;
        logic [P-1:0]       prod_pn [1:PIPE_STAGES-1];
        always_ff @(posedge clk) begin
            a_p0       <= operandA;
            b_p0       <= operandB;
            prod_pn[1] <= mul_full(a_p0, b_p0);
            for (int k = 2; k < PIPE_STAGES; k++) prod_pn[k] <= prod_pn[k-1];
        end
        assign wr_data = prod_pn[PIPE_STAGES-1];
    end

    // ---- memory: last pipeline stage writes, the burst reads ----
    memory_wrapper_2port #(
        .WIDTH    (P),
        .LOGDEPTH (AW)
    ) u_mem (
        .clk  (clk),
        .cenA (~rd_active),
        .aA   (rd_addr[AW-1:0]),
        .q    (memVal),
        .cenB (~vld_p[PIPE_STAGES-1]),
        .aB   (wa_p[PIPE_STAGES-1]),
        .d    (wr_data)
    );

endmodule

// File: tb/tb_mult_result_buffer_pipelined.sv
// Bench for mult_result_buffer_pipelined. Two instances share one stimulus:
// instance 0 is unsigned with 3 pipeline stages, instance 1 is signed with
// 2 stages. Both have DEPTH 64. A behavioural model of each buffer is
// stepped every clock, and every cycle the DUT outputs are compared with it.
module tb_mult_result_buffer_pipelined;

    localparam int DEPTH    = 64;
    localparam int ST_FILL  = 0;
    localparam int ST_DRAIN = 1;
    localparam int ST_FULL  = 2;
    localparam int ST_READ  = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] operandA, operandB;
    logic        EN_mult, flush, EN_readMem;
    logic [1:0]  rdy_mult, rdy_read, vld_mem;
    logic [31:0] mem_val [2];
    logic [6:0]  fcnt [2];

    mult_result_buffer_pipelined #(.A_WIDTH(16), .B_WIDTH(16), .DEPTH(DEPTH),
                                   .PIPE_STAGES(3), .SIGNED(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .operandA(operandA), .operandB(operandB),
        .EN_mult(EN_mult), .flush(flush), .EN_readMem(EN_readMem),
        .RDY_mult(rdy_mult[0]), .RDY_readMem(rdy_read[0]), .memVal(mem_val[0]),
        .VALID_memVal(vld_mem[0]), .fill_count(fcnt[0]));

    mult_result_buffer_pipelined #(.A_WIDTH(16), .B_WIDTH(16), .DEPTH(DEPTH),
                                   .PIPE_STAGES(2), .SIGNED(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .operandA(operandA), .operandB(operandB),
        .EN_mult(EN_mult), .flush(flush), .EN_readMem(EN_readMem),
        .RDY_mult(rdy_mult[1]), .RDY_readMem(rdy_read[1]), .memVal(mem_val[1]),
        .VALID_memVal(vld_mem[1]), .fill_count(fcnt[1]));

    int tests = 0;
    int fails = 0;

    // model state
    int          m_state [2];
    int          m_cnt [2];
    int          m_ridx [2];
    longint      m_edge = 0;
    longint      m_last_acc [2];
    longint      m_drain [2];
    logic [31:0] m_mem [2][DEPTH];

    // burst capture
    int          vcnt [2];
    logic [31:0] cap [2][DEPTH];
    logic [1:0]  prev_vld = 2'b00;

    function automatic int pipe_of(input int d);
        return (d == 0) ? 3 : 2;
    endfunction

    function automatic logic [31:0] prod_m(input int sg, input logic [15:0] a, input logic [15:0] b);
        longint x, y, p;
        x = (sg != 0) ? longint'($signed(a)) : longint'(a);
        y = (sg != 0) ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return p[31:0];
    endfunction

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[dut%0d] got=0x%0h want=0x%0h", nm, d, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_state[d]    = ST_FILL;
            m_cnt[d]      = 0;
            m_ridx[d]     = 0;
            m_last_acc[d] = 0;
            m_drain[d]    = 0;
        end
    endtask

    // One clock edge of the behavioural model, using the inputs present at the edge.
    task automatic model_step();
        bit acc, fl;
        m_edge++;
        for (int d = 0; d < 2; d++) begin
            case (m_state[d])
                ST_FILL: begin
                    acc = EN_mult && (m_cnt[d] < DEPTH);
                    fl  = flush && ((m_cnt[d] > 0) || acc);
                    if (acc) begin
                        m_mem[d][m_cnt[d]] = prod_m(d, operandA, operandB);
                        m_cnt[d]++;
                        m_last_acc[d] = m_edge;
                    end
                    if ((m_cnt[d] == DEPTH) || fl) begin
                        m_state[d] = ST_DRAIN;
                        m_drain[d] = m_edge;
                    end
                end
                ST_DRAIN: begin
                    // Last product is written PIPE edges after its accept; the
                    // buffer is offered one edge after that, and never sooner
                    // than one edge after entering the drain.
                    if ((m_edge >= m_last_acc[d] + pipe_of(d) + 1) && (m_edge >= m_drain[d] + 1))
                        m_state[d] = ST_FULL;
                end
                ST_FULL: begin
                    if (EN_readMem) begin
                        m_state[d] = ST_READ;
                        m_ridx[d]  = 0;
                    end
                end
                default: begin
                    if (m_ridx[d] == m_cnt[d]) begin
                        m_state[d] = ST_FILL;
                        m_cnt[d]   = 0;
                        m_ridx[d]  = 0;
                    end else begin
                        m_ridx[d]++;
                    end
                end
            endcase
        end
    endtask

    task automatic compare();
        logic ev;
        for (int d = 0; d < 2; d++) begin
            ev = (m_state[d] == ST_READ) && (m_ridx[d] >= 1);
            chk("RDY_mult", d, 64'(rdy_mult[d]), 64'((m_state[d] == ST_FILL) && (m_cnt[d] < DEPTH)));
            chk("RDY_readMem", d, 64'(rdy_read[d]), 64'(m_state[d] == ST_FULL));
            chk("VALID_memVal", d, 64'(vld_mem[d]), 64'(ev));
            chk("fill_count", d, 64'(fcnt[d]), 64'(m_cnt[d]));
            if (ev) chk("memVal", d, 64'(mem_val[d]), 64'(m_mem[d][m_ridx[d]-1]));
            if (vld_mem[d] === 1'b1) begin
                if (prev_vld[d] !== 1'b1) vcnt[d] = 0;
                if (vcnt[d] < DEPTH) cap[d][vcnt[d]] = mem_val[d];
                vcnt[d]++;
            end
            prev_vld[d] = (vld_mem[d] === 1'b1);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic fl);
        operandA = a;
        operandB = b;
        EN_mult  = 1'b1;
        flush    = fl;
        tick();
        EN_mult  = 1'b0;
        flush    = 1'b0;
    endtask

    // Returns the number of edges until each DUT raises RDY_readMem (-1 if never).
    task automatic wait_ready(output int l0, output int l1);
        l0 = -1;
        l1 = -1;
        for (int j = 1; j <= 40 && (l0 < 0 || l1 < 0); j++) begin
            tick();
            if (rdy_read[0] && l0 < 0) l0 = j;
            if (rdy_read[1] && l1 < 0) l1 = j;
        end
    endtask

    task automatic do_read(input int n, input bit junk);
        EN_readMem = 1'b1;
        if (junk) begin
            EN_mult  = 1'b1;
            operandA = 16'hDEAD;
            operandB = 16'hBEEF;
        end
        tick();
        EN_readMem = 1'b0;
        tick();
        EN_mult = 1'b0;
        repeat (n + 3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int l0, l1;
        rst_n = 1'b1; operandA = '0; operandB = '0;
        EN_mult = 1'b0; flush = 1'b0; EN_readMem = 1'b0;
        vcnt[0] = 0; vcnt[1] = 0;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            chk("reset_rdy_mult", d, 64'(rdy_mult[d]), 64'd1);
            chk("reset_rdy_read", d, 64'(rdy_read[d]), 64'd0);
            chk("reset_valid", d, 64'(vld_mem[d]), 64'd0);
            chk("reset_fcnt", d, 64'(fcnt[d]), 64'd0);
        end
        rst_n = 1'b1;

        // model pins
        chk("model_s_neg3x5", 1, 64'(prod_m(1, 16'hFFFD, 16'd5)), 64'h0000_0000_FFFF_FFF1);
        chk("model_s_minxmin", 1, 64'(prod_m(1, 16'h8000, 16'h8000)), 64'h0000_0000_4000_0000);
        chk("model_s_maxxm1", 1, 64'(prod_m(1, 16'h7FFF, 16'hFFFF)), 64'h0000_0000_FFFF_8001);
        chk("model_u_fffdx5", 0, 64'(prod_m(0, 16'hFFFD, 16'd5)), 64'h0000_0000_0004_FFF1);

        // full fill of 64 pairs (i, i+1)
        for (int i = 0; i < DEPTH; i++) push(16'(i), 16'(i + 1), 1'b0);
        for (int d = 0; d < 2; d++) chk("full_rdy_mult_drop", d, 64'(rdy_mult[d]), 64'd0);
        wait_ready(l0, l1);
        chk("full_drain_lat", 0, 64'(l0), 64'd4);
        chk("full_drain_lat", 1, 64'(l1), 64'd3);
        do_read(DEPTH, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk("full_vcnt", d, 64'(vcnt[d]), 64'd64);
            chk("full_cap0", d, 64'(cap[d][0]), 64'd0);
            chk("full_cap10", d, 64'(cap[d][10]), 64'd110);
            chk("full_cap63", d, 64'(cap[d][63]), 64'd4032);
            chk("full_rdy_after", d, 64'(rdy_mult[d]), 64'd1);
        end

        // EN_readMem during FILL is ignored
        EN_readMem = 1'b1;
        tick();
        tick();
        EN_readMem = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("misuse_fill_rdy_read", d, 64'(rdy_read[d]), 64'd0);
            chk("misuse_fill_fcnt", d, 64'(fcnt[d]), 64'd0);
        end

        // signed corner operands, flush with the third accept
        push(16'hFFFD, 16'd5, 1'b0);
        push(16'h8000, 16'h8000, 1'b0);
        push(16'h7FFF, 16'hFFFF, 1'b1);
        wait_ready(l0, l1);
        EN_mult = 1'b1; operandA = 16'h1234; operandB = 16'h5678;
        repeat (3) tick();
        EN_mult = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("misuse_full_fcnt", d, 64'(fcnt[d]), 64'd3);
            chk("misuse_full_rdy_read", d, 64'(rdy_read[d]), 64'd1);
        end
        do_read(3, 1'b1);
        chk("sgn_vcnt", 1, 64'(vcnt[1]), 64'd3);
        chk("sgn_cap0", 1, 64'(cap[1][0]), 64'hFFFF_FFF1);
        chk("sgn_cap1", 1, 64'(cap[1][1]), 64'h4000_0000);
        chk("sgn_cap2", 1, 64'(cap[1][2]), 64'hFFFF_8001);
        chk("uns_vcnt", 0, 64'(vcnt[0]), 64'd3);
        chk("uns_cap0", 0, 64'(cap[0][0]), 64'h0004_FFF1);
        chk("uns_cap1", 0, 64'(cap[0][1]), 64'h4000_0000);
        chk("uns_cap2", 0, 64'(cap[0][2]), 64'h7FFE_8001);

        // partial fill: flush with the 5th accept
        for (int i = 0; i < 5; i++) push(16'(10 + i), 16'd3, (i == 4));
        for (int d = 0; d < 2; d++) chk("part_fcnt", d, 64'(fcnt[d]), 64'd5);
        wait_ready(l0, l1);
        do_read(5, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk("part_vcnt", d, 64'(vcnt[d]), 64'd5);
            chk("part_cap0", d, 64'(cap[d][0]), 64'd30);
            chk("part_cap4", d, 64'(cap[d][4]), 64'd42);
        end

        // flush with nothing issued is ignored
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("empty_flush_rdy_mult", d, 64'(rdy_mult[d]), 64'd1);
            chk("empty_flush_rdy_read", d, 64'(rdy_read[d]), 64'd0);
        end

        // gapped input, flush one cycle after the last accept
        for (int i = 0; i < 6; i++) begin
            push(16'(100 * i + 7), 16'(i + 2), 1'b0);
            if (i < 5) tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_ready(l0, l1);
        chk("gap_drain_lat", 0, 64'(l0), 64'd3);
        chk("gap_drain_lat", 1, 64'(l1), 64'd2);
        do_read(6, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk("gap_vcnt", d, 64'(vcnt[d]), 64'd6);
            chk("gap_cap0", d, 64'(cap[d][0]), 64'd14);
            chk("gap_cap5", d, 64'(cap[d][5]), 64'd3549);
        end

        // reset during the 10th valid cycle of a 20-entry burst
        for (int i = 0; i < 20; i++) push(16'(i + 1), 16'(2 * i + 1), (i == 19));
        wait_ready(l0, l1);
        EN_readMem = 1'b1;
        tick();
        EN_readMem = 1'b0;
        for (int j = 0; j < 40 && vcnt[0] < 9; j++) tick();
        chk("rst_wait_vcnt", 0, 64'(vcnt[0]), 64'd9);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("midrst_valid", d, 64'(vld_mem[d]), 64'd0);
            chk("midrst_rdy_mult", d, 64'(rdy_mult[d]), 64'd1);
            chk("midrst_rdy_read", d, 64'(rdy_read[d]), 64'd0);
            chk("midrst_fcnt", d, 64'(fcnt[d]), 64'd0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) push(16'(1000 + i), 16'd3, (i == 2));
        wait_ready(l0, l1);
        do_read(3, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk("post_rst_vcnt", d, 64'(vcnt[d]), 64'd3);
            chk("post_rst_cap0", d, 64'(cap[d][0]), 64'd3000);
            chk("post_rst_cap2", d, 64'(cap[d][2]), 64'd3006);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
